// File: rtl/tcore_param.sv
// Shared core parameters and the fetch-queue entry type.
package tcore_param;

   localparam int FB_DEPTH = 4;
   localparam int TC_XLEN  = 32;

   typedef struct packed {
      logic [TC_XLEN-1:0] pc;
      logic [TC_XLEN-1:0] instr;
      logic [4:0]         exc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and the decode register; holds under stall_de, empties on flush_de.
// Optional same-cycle empty bypass from fetch to decode: define FETCH_BUF_BYPASS_EN.
module fetch_buffer
   import tcore_param::*;
#(
   parameter int DEPTH = FB_DEPTH,
   parameter int XLEN  = TC_XLEN
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       fe_valid_i,
   input  logic [XLEN-1:0]            fe_pc_i,
   input  logic [XLEN-1:0]            fe_instr_i,
   input  logic [4:0]                 fe_exc_i,
   output logic                       fe_ready_o,
   input  logic                       stall_de_i,
   input  logic                       flush_de_i,
   output logic                       de_valid_o,
   output logic [XLEN-1:0]            de_pc_o,
   output logic [XLEN-1:0]            de_instr_o,
   output logic [4:0]                 de_exc_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          ready_r;
   logic          valid_r;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;
   fetch_entry_t  fe_entry_s;
   fetch_entry_t  head_s;

   // Push/pop decision, next occupancy and head selection
   always_comb begin
      fe_entry_s.pc    = TC_XLEN'(fe_pc_i);
      fe_entry_s.instr = TC_XLEN'(fe_instr_i);
      fe_entry_s.exc   = fe_exc_i;
`ifdef FETCH_BUF_BYPASS_EN
      bypass_s = (count_r == CW'(0)) && fe_valid_i && !flush_de_i;
`else
      bypass_s = 1'b0;
`endif
      // A bypassed entry that decode takes right away is never stored
      push_s = fe_valid_i && ready_r && !flush_de_i && !(bypass_s && !stall_de_i);
      pop_s  = valid_r && !stall_de_i && !flush_de_i;
      if (flush_de_i) begin
         count_nxt_s = CW'(0);
      end else if (push_s && !pop_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
      if (bypass_s) begin
         head_s = fe_entry_s;
      end else begin
         head_s = mem_r[rptr_r];
      end
   end

   // Storage, pointers, occupancy and registered status flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wptr_r  <= AW'(0);
         rptr_r  <= AW'(0);
         count_r <= CW'(0);
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         ready_r <= (count_nxt_s != CW'(DEPTH));
         valid_r <= (count_nxt_s != CW'(0));
         if (flush_de_i) begin
            wptr_r <= AW'(0);
            rptr_r <= AW'(0);
         end else begin
            if (push_s) begin
               mem_r[wptr_r] <= fe_entry_s;
               wptr_r        <= wptr_r + AW'(1);
            end
            if (pop_s) begin
               rptr_r <= rptr_r + AW'(1);
            end
         end
      end
   end

   assign fe_ready_o = ready_r;
   assign de_valid_o = valid_r || bypass_s;
   assign de_pc_o    = XLEN'(head_s.pc);
   assign de_instr_o = XLEN'(head_s.instr);
   assign de_exc_o   = head_s.exc;
   assign level_o    = count_r;

endmodule
